trigger_ctrl: RTL and testbench
===============================

TRIGGER_CTRL -- requirements
Module: trigger_ctrl

Interface
REQ-001 Parameters SHALL be, as name, default, meaning:
  N_CH, 16, number of hit channels;
  MIN_HITS, 2, distinct channels needed for coincidence;
  WINDOW, 8, coincidence window in cycles;
  HOLDOFF, 64, dead cycles after each event;
  SAVE_TO, 4096, event_saved_i timeout in cycles.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, as name, direction, width, meaning:
  clk, in, 1, sole clock (125 MHz domain);
  rst, in, 1, asynchronous active-low reset;
  hit_i, in, N_CH, per-channel discriminator level, synchronous to clk;
  arm_i, in, 1, level, enables triggering;
  full_i, in, 1, downstream FIFO full;
  event_saved_i, in, 1, one-cycle pulse from the saver when an event is stored;
  trigger_o, out, 1, one-cycle trigger pulse to the saver;
  busy_o, out, 1, high in every state except IDLE and ARMED;
  hit_mask_o, out, N_CH, channels that formed the last trigger;
  trig_count_o, out, 32, triggers issued, wraps;
  dead_count_o, out, 16, missed hit edges, saturates;
  err_o, out, 1, sticky save-timeout flag.

Function
REQ-004 The FSM SHALL have six states: IDLE, ARMED, COINC, FIRE, WAIT_SAVE and HOLDOFF.
REQ-005 A hit edge on channel k SHALL be defined as hit_i[k]=1 at this edge and 0 at the previous sampling edge, using one internal register stage.
REQ-006 IDLE SHALL go to ARMED when arm_i=1.
REQ-007 In ARMED or COINC, arm_i=0 SHALL force IDLE and clear the window mask.
REQ-008 In ARMED, any hit edge SHALL OR into the window mask, load the window counter with WINDOW-1, and go to COINC.
REQ-009 In COINC, new edges SHALL OR into the mask, and the counter SHALL decrement each cycle.
REQ-010 In COINC, if popcount(mask) >= MIN_HITS and full_i=0, the FSM SHALL go to FIRE.
REQ-011 In COINC, if the counter reaches 0 without qualifying, the FSM SHALL clear the mask and return to ARMED.
REQ-012 Simultaneous edges on several channels in one cycle SHALL all count; if they alone meet MIN_HITS, ARMED SHALL go directly to FIRE.
REQ-013 Qualification while full_i=1 SHALL NOT fire.
  - The FSM stays in COINC until full_i falls or the window expires.
  - Each blocked qualifying cycle increments dead_count_o.
REQ-014 Latency: if the qualifying edge is sampled at clock edge N, trigger_o SHALL be high exactly from edge N+2 to edge N+3.
REQ-015 FIRE SHALL last one cycle and SHALL:
  - assert trigger_o;
  - increment trig_count_o (wraps from 0xFFFFFFFF to 0);
  - latch the mask into hit_mask_o;
  - clear the mask;
  - go to WAIT_SAVE.
REQ-016 WAIT_SAVE SHALL go to HOLDOFF on event_saved_i=1.
REQ-017 WAIT_SAVE SHALL go to HOLDOFF, setting err_o, after SAVE_TO cycles without event_saved_i; err_o clears only on reset.
REQ-018 event_saved_i outside WAIT_SAVE SHALL be ignored.
REQ-019 HOLDOFF SHALL last exactly HOLDOFF cycles, then go to ARMED if arm_i=1, else IDLE.
REQ-020 arm_i SHALL be ignored in FIRE, WAIT_SAVE and HOLDOFF.
REQ-021 In WAIT_SAVE and HOLDOFF, each cycle with at least one hit edge SHALL increment dead_count_o by 1, saturating at 0xFFFF.
REQ-022 All outputs SHALL be registered.

Reset
REQ-023 While rst=0, the block SHALL immediately set:
  - state to IDLE;
  - trigger_o, busy_o and err_o to 0;
  - hit_mask_o, trig_count_o and dead_count_o to 0;
  - the internal mask, the counters and the edge register to 0.
REQ-024 Reset asserted mid-FIRE SHALL truncate trigger_o.
REQ-025 After rst rises, the first cycle SHALL NOT detect an edge on any channel already high.

Verification
REQ-026 Case 1: arm_i=1; hit_i[0] rises at edge 10, hit_i[5] at edge 13 -> trigger_o high edge 15 to 16, hit_mask_o=0x0021, trig_count_o=1.
REQ-027 Case 2: hit_i[2] rises, hit_i[3] rises 9 cycles later (WINDOW=8) -> no trigger; the FSM returns to ARMED; the second edge starts a new window.
REQ-028 Case 3: hit_i=0x0003 rises in one cycle -> direct ARMED to FIRE, trigger at N+2, hit_mask_o=0x0003.
REQ-029 Case 4: after a trigger, event_saved_i at +5 cycles; a hit edge at +20 -> dead_count_o=1, busy_o low exactly 64 cycles after the save, no second trigger.
REQ-030 Case 5: no event_saved_i -> err_o=1 after 4096 cycles in WAIT_SAVE, then HOLDOFF, then ARMED.
REQ-031 Case 6: full_i=1 during a qualifying coincidence, dropping 3 cycles later inside the window -> dead_count_o=3, trigger the cycle after full_i falls; a rst pulse then zeroes all outputs.

Source files
------------

// File: rtl/trigger_ctrl.sv
// trigger_ctrl: coincidence trigger for N_CH discriminator channels.
// Rising edges on distinct channels are collected in a mask during a short
// window; enough distinct channels fire a one-cycle trigger, then the block
// waits for the saver to acknowledge and sits out a fixed dead time.
//
// Handshake with the saver: trigger_o is a single-cycle request. The saver
// answers with a single-cycle event_saved_i pulse, which is only honoured
// in WAIT_SAVE. If no answer arrives within SAVE_TO cycles, the block moves
// on by itself and raises the sticky err_o flag. full_i is a level
// back-pressure: while high, a qualifying coincidence is held, not fired.
//
// Pipeline: hit_i is compared with its previous sample to find rising edges.
// The edge vector is registered before the FSM consumes it. Together with
// the registered trigger_o, this puts the trigger pulse two edges after the
// edge that sampled the qualifying hit.
module trigger_ctrl #(
    parameter int N_CH     = 16,
    parameter int MIN_HITS = 2,
    parameter int WINDOW   = 8,
    parameter int HOLDOFF  = 64,
    parameter int SAVE_TO  = 4096
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] hit_i,
    input  logic            arm_i,
    input  logic            full_i,
    input  logic            event_saved_i,
    output logic            trigger_o,
    output logic            busy_o,
    output logic [N_CH-1:0] hit_mask_o,
    output logic [31:0]     trig_count_o,
    output logic [15:0]     dead_count_o,
    output logic            err_o,
    output logic [2:0]      state_dbg
);

    // One shared down-counter serves the window, save timeout and hold-off.
    localparam int TMR_MAX = (SAVE_TO > HOLDOFF)
                             ? ((SAVE_TO > WINDOW) ? SAVE_TO : WINDOW)
                             : ((HOLDOFF > WINDOW) ? HOLDOFF : WINDOW);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_COINC     = 3'd2,
        ST_FIRE      = 3'd3,
        ST_WAIT_SAVE = 3'd4,
        ST_HOLDOFF   = 3'd5
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [N_CH-1:0]   hit_d;      // previous sample of hit_i
    logic              primed;     // low for the first cycle after reset
    logic [N_CH-1:0]   edge_q;     // registered rising edges
    logic [N_CH-1:0]   mask;       // channels seen in the current window
    logic [N_CH-1:0]   mask_n;
    logic [TMR_W-1:0]  tmr;
    logic [TMR_W-1:0]  tmr_n;
    logic [N_CH-1:0]   cand;       // mask including this cycle's edges
    logic              qual;       // cand holds enough distinct channels
    logic              dead_inc;
    logic              err_set;

    // Count the set bits of a channel vector.
    function automatic int popcount(input logic [N_CH-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < N_CH; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

    assign state_dbg = state;

    // Edge detection. The first cycle after reset only loads hit_d, so a
    // channel that was already high during reset never looks like an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_d  <= '0;
            primed <= 1'b0;
            edge_q <= '0;
        end else begin
            hit_d  <= hit_i;
            primed <= 1'b1;
            edge_q <= primed ? (hit_i & ~hit_d) : '0;
        end
    end

    // State, window mask and shared timer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            mask  <= '0;
            tmr   <= '0;
        end else begin
            state <= state_n;
            mask  <= mask_n;
            tmr   <= tmr_n;
        end
    end

    // Next-state logic, window bookkeeping and event strobes.
    always_comb begin
        state_n  = state;
        mask_n   = mask;
        tmr_n    = tmr;
        dead_inc = 1'b0;
        err_set  = 1'b0;
        cand     = mask | edge_q;
        qual     = (popcount(cand) >= MIN_HITS);

        case (state)
            ST_IDLE: begin
                if (arm_i) begin
                    state_n = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (!arm_i) begin
                    state_n = ST_IDLE;
                    mask_n  = '0;
                end else if (|edge_q) begin
                    // First edge(s) open a window; simultaneous edges that
                    // already qualify skip straight to FIRE.
                    mask_n = cand;
                    tmr_n  = TMR_W'(WINDOW - 1);
                    if (qual && !full_i) begin
                        state_n = ST_FIRE;
                    end else begin
                        state_n  = ST_COINC;
                        dead_inc = qual;
                    end
                end
            end

            ST_COINC: begin
                if (!arm_i) begin
                    state_n = ST_IDLE;
                    mask_n  = '0;
                end else begin
                    mask_n = cand;
                    if (qual && !full_i) begin
                        state_n = ST_FIRE;
                    end else begin
                        // A qualifying cycle blocked by full_i is a lost event.
                        dead_inc = qual;
                        if (tmr == '0) begin
                            state_n = ST_ARMED;
                            mask_n  = '0;
                        end else begin
                            tmr_n = tmr - TMR_W'(1);
                        end
                    end
                end
            end

            ST_FIRE: begin
                mask_n  = '0;
                state_n = ST_WAIT_SAVE;
                tmr_n   = TMR_W'(SAVE_TO - 1);
            end

            ST_WAIT_SAVE: begin
                dead_inc = |edge_q;
                if (event_saved_i) begin
                    state_n = ST_HOLDOFF;
                    tmr_n   = TMR_W'(HOLDOFF - 1);
                end else if (tmr == '0) begin
                    state_n = ST_HOLDOFF;
                    tmr_n   = TMR_W'(HOLDOFF - 1);
                    err_set = 1'b1;
                end else begin
                    tmr_n = tmr - TMR_W'(1);
                end
            end

            ST_HOLDOFF: begin
                dead_inc = |edge_q;
                if (tmr == '0) begin
                    state_n = arm_i ? ST_ARMED : ST_IDLE;
                end else begin
                    tmr_n = tmr - TMR_W'(1);
                end
            end

            default: begin
                state_n = ST_IDLE;
                mask_n  = '0;
                tmr_n   = '0;
            end
        endcase
    end

    // Registered trigger pulse and busy flag; busy tracks the next state so
    // it is high in exactly the busy states.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trigger_o <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            trigger_o <= (state == ST_FIRE);
            busy_o    <= (state_n != ST_IDLE) && (state_n != ST_ARMED);
        end
    end

    // Trigger bookkeeping captured as FIRE completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_mask_o   <= '0;
            trig_count_o <= '0;
        end else if (state == ST_FIRE) begin
            hit_mask_o   <= mask;
            trig_count_o <= trig_count_o + 32'd1;
        end
    end

    // Saturating dead-hit counter and sticky save-timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dead_count_o <= '0;
            err_o        <= 1'b0;
        end else begin
            if (dead_inc && (dead_count_o != 16'hFFFF)) begin
                dead_count_o <= dead_count_o + 16'd1;
            end
            if (err_set) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trigger_ctrl.sv
// Directed bench for trigger_ctrl with default parameters.
module tb_trigger_ctrl;

    localparam logic [31:0] S_IDLE  = 32'd0;
    localparam logic [31:0] S_ARMED = 32'd1;
    localparam logic [31:0] S_COINC = 32'd2;
    localparam logic [31:0] S_FIRE  = 32'd3;
    localparam logic [31:0] S_WAIT  = 32'd4;
    localparam logic [31:0] S_HOLD  = 32'd5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] hit_i = '0;
    logic        arm_i = 1'b0;
    logic        full_i = 1'b0;
    logic        event_saved_i = 1'b0;
    logic        trigger_o;
    logic        busy_o;
    logic [15:0] hit_mask_o;
    logic [31:0] trig_count_o;
    logic [15:0] dead_count_o;
    logic        err_o;
    logic [2:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    trigger_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .hit_i         (hit_i),
        .arm_i         (arm_i),
        .full_i        (full_i),
        .event_saved_i (event_saved_i),
        .trigger_o     (trigger_o),
        .busy_o        (busy_o),
        .hit_mask_o    (hit_mask_o),
        .trig_count_o  (trig_count_o),
        .dead_count_o  (dead_count_o),
        .err_o         (err_o),
        .state_dbg     (state_dbg)
    );

    // clock
    always #5 clk = ~clk;

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_trig"}, {31'd0, trigger_o}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_err"}, {31'd0, err_o}, 32'd0);
        check({tag, "_mask"}, {16'd0, hit_mask_o}, 32'd0);
        check({tag, "_cnt"}, trig_count_o, 32'd0);
        check({tag, "_dead"}, {16'd0, dead_count_o}, 32'd0);
        check({tag, "_state"}, {29'd0, state_dbg}, S_IDLE);
    endtask

    initial begin
        // reset
        #1 rst = 1'b0;
        step(2);
        check_zero_outputs("rst");
        rst = 1'b1;
        step(2);
        check("idle_no_arm", {29'd0, state_dbg}, S_IDLE);
        arm_i = 1'b1;
        step(2);
        check("armed", {29'd0, state_dbg}, S_ARMED);
        check("armed_busy", {31'd0, busy_o}, 32'd0);

        // saver pulse outside WAIT_SAVE is ignored
        event_saved_i = 1'b1;
        step(1);
        event_saved_i = 1'b0;
        step(1);
        check("es_ignored", {29'd0, state_dbg}, S_ARMED);

        // case 1: ch0 at edge 10, ch5 at edge 13, trigger 15..16
        hit_i = 16'h0001;
        step(1);
        step(1);
        check("c1_coinc", {29'd0, state_dbg}, S_COINC);
        step(1);
        hit_i = 16'h0021;
        step(1);
        check("c1_trig_n0", {31'd0, trigger_o}, 32'd0);
        step(1);
        check("c1_fire", {29'd0, state_dbg}, S_FIRE);
        check("c1_trig_n1", {31'd0, trigger_o}, 32'd0);
        check("c1_busy", {31'd0, busy_o}, 32'd1);
        step(1);
        check("c1_trig_n2", {31'd0, trigger_o}, 32'd1);
        check("c1_mask", {16'd0, hit_mask_o}, 32'h21);
        check("c1_cnt", trig_count_o, 32'd1);
        check("c1_wait", {29'd0, state_dbg}, S_WAIT);
        step(1);
        check("c1_trig_n3", {31'd0, trigger_o}, 32'd0);
        hit_i = 16'h0000;

        // case 4: save at trigger+5, hit edge at trigger+20
        step(3);
        event_saved_i = 1'b1;
        step(1);
        event_saved_i = 1'b0;
        check("c4_hold", {29'd0, state_dbg}, S_HOLD);
        check("c4_dead0", {16'd0, dead_count_o}, 32'd0);
        step(14);
        hit_i = 16'h0080;
        step(2);
        check("c4_dead1", {16'd0, dead_count_o}, 32'd1);
        step(47);
        check("c4_busy_63", {31'd0, busy_o}, 32'd1);
        check("c4_state_63", {29'd0, state_dbg}, S_HOLD);
        step(1);
        check("c4_busy_64", {31'd0, busy_o}, 32'd0);
        check("c4_armed", {29'd0, state_dbg}, S_ARMED);
        check("c4_cnt", trig_count_o, 32'd1);
        hit_i = 16'h0000;
        step(2);

        // case 2: ch2 then ch3 nine cycles later, then ch4 in the new window
        hit_i = 16'h0004;
        step(1);
        step(8);
        check("c2_coinc_last", {29'd0, state_dbg}, S_COINC);
        hit_i = 16'h000C;
        step(1);
        check("c2_expired", {29'd0, state_dbg}, S_ARMED);
        check("c2_no_trig", trig_count_o, 32'd1);
        step(1);
        check("c2_new_window", {29'd0, state_dbg}, S_COINC);
        step(1);
        hit_i = 16'h001C;
        step(2);
        check("c2_fire", {29'd0, state_dbg}, S_FIRE);
        step(1);
        check("c2_trig", {31'd0, trigger_o}, 32'd1);
        check("c2_mask", {16'd0, hit_mask_o}, 32'h18);
        check("c2_cnt", trig_count_o, 32'd2);
        hit_i = 16'h0000;

        // case 5: no save, timeout after 4096 cycles in WAIT_SAVE
        step(4095);
        check("c5_wait_last", {29'd0, state_dbg}, S_WAIT);
        check("c5_err_before", {31'd0, err_o}, 32'd0);
        step(1);
        check("c5_err", {31'd0, err_o}, 32'd1);
        check("c5_hold", {29'd0, state_dbg}, S_HOLD);
        step(64);
        check("c5_armed", {29'd0, state_dbg}, S_ARMED);
        check("c5_err_sticky", {31'd0, err_o}, 32'd1);
        check("c5_dead", {16'd0, dead_count_o}, 32'd1);

        // case 3: two channels in one cycle fire directly
        hit_i = 16'h0003;
        step(1);
        check("c3_trig_n0", {31'd0, trigger_o}, 32'd0);
        step(1);
        check("c3_fire", {29'd0, state_dbg}, S_FIRE);
        step(1);
        check("c3_trig", {31'd0, trigger_o}, 32'd1);
        check("c3_mask", {16'd0, hit_mask_o}, 32'h03);
        check("c3_cnt", trig_count_o, 32'd3);
        event_saved_i = 1'b1;
        step(1);
        event_saved_i = 1'b0;
        step(64);
        check("c3_armed", {29'd0, state_dbg}, S_ARMED);
        hit_i = 16'h0000;
        step(1);

        // disarm inside a window
        hit_i = 16'h0010;
        step(2);
        check("disarm_coinc", {29'd0, state_dbg}, S_COINC);
        arm_i = 1'b0;
        step(1);
        check("disarm_idle", {29'd0, state_dbg}, S_IDLE);
        arm_i = 1'b1;
        step(1);
        check("rearm", {29'd0, state_dbg}, S_ARMED);
        hit_i = 16'h0000;

        // reset with ch0 held high: no edge after release
        hit_i = 16'h0001;
        rst = 1'b0;
        #1;
        check_zero_outputs("rst2");
        step(2);
        rst = 1'b1;
        step(1);
        check("rel_armed", {29'd0, state_dbg}, S_ARMED);
        step(1);
        check("rel_no_edge", {29'd0, state_dbg}, S_ARMED);
        step(1);
        check("rel_no_edge2", {29'd0, state_dbg}, S_ARMED);

        // case 6: coincidence blocked by full_i for three cycles
        full_i = 1'b1;
        hit_i = 16'h0003;
        step(1);
        step(1);
        hit_i = 16'h0007;
        step(2);
        check("c6_dead1", {16'd0, dead_count_o}, 32'd1);
        step(2);
        check("c6_dead3", {16'd0, dead_count_o}, 32'd3);
        check("c6_blocked", {29'd0, state_dbg}, S_COINC);
        check("c6_no_trig", {31'd0, trigger_o}, 32'd0);
        full_i = 1'b0;
        step(1);
        check("c6_fire", {29'd0, state_dbg}, S_FIRE);
        step(1);
        check("c6_trig", {31'd0, trigger_o}, 32'd1);
        check("c6_mask", {16'd0, hit_mask_o}, 32'h06);
        check("c6_cnt", trig_count_o, 32'd1);
        check("c6_dead_final", {16'd0, dead_count_o}, 32'd3);

        // reset during the trigger pulse truncates it
        rst = 1'b0;
        #1;
        check_zero_outputs("rst3");
        step(1);
        rst = 1'b1;
        step(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
